updown_counter: RTL



---
 rtl/counter_pkg.sv | 27 ++
 rtl/updown_step.sv | 67 ++++++
 rtl/updown_counter.sv | 79 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction encoding,
// terminal-value helper and load clamping.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam int   MAX_WIDTH = 32;

   // Highest count value of a modulo-MODULUS counter; timers and prescalers reuse this.
   function automatic logic [MAX_WIDTH-1:0] term_value(input longint modulus);
      longint t;
      t = modulus - 64'sd1;
      return t[MAX_WIDTH-1:0];
   endfunction

   function automatic logic [MAX_WIDTH-1:0] clamp_load(input logic [MAX_WIDTH-1:0] d,
                                                       input longint            modulus);
      longint d_ext;
      d_ext = longint'({32'h0000_0000, d});
      if (d_ext >= modulus) begin
         return term_value(modulus);
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/updown_step.sv
// One count step of a modulo-MODULUS up/down counter: next value and terminal flag.
// COUNTER_SATURATE_EN selects saturation at the limits instead of wrapping.
module updown_step
   import counter_pkg::*;
#(
   parameter int     WIDTH   = 8,
   parameter longint MODULUS = 256
) (
   input  logic [WIDTH-1:0] value,
   input  logic             up,
   output logic [WIDTH-1:0] next,
   output logic             term
);

   localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(term_value(MODULUS));
   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
   localparam bit               FULL     = (MODULUS == (64'sd1 <<< WIDTH));

`ifdef COUNTER_SATURATE_EN
   localparam logic [WIDTH-1:0] TOP_NEXT = TERM_VAL;
   localparam logic [WIDTH-1:0] BOT_NEXT = ZERO_VAL;
`else
   localparam logic [WIDTH-1:0] TOP_NEXT = ZERO_VAL;
   localparam logic [WIDTH-1:0] BOT_NEXT = TERM_VAL;
`endif

   logic [WIDTH:0] inc_s;
   logic [WIDTH:0] dec_s;
   logic           at_top_s;
   logic           at_bot_s;

   assign inc_s = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_s = {1'b0, value} - {{WIDTH{1'b0}}, 1'b1};

   // A full-range counter detects its limits from the natural carry/borrow bit.
   assign at_top_s = FULL ? inc_s[WIDTH] : (value == TERM_VAL);
   assign at_bot_s = FULL ? dec_s[WIDTH] : (value == ZERO_VAL);

   // Direction-dependent step with limit handling.
   always_comb begin
      next = value;
      term = 1'b0;
      case (up)
         DIR_UP: begin
            term = at_top_s;
            if (at_top_s) begin
               next = TOP_NEXT;
            end else begin
               next = inc_s[WIDTH-1:0];
            end
         end
         DIR_DOWN: begin
            term = at_bot_s;
            if (at_bot_s) begin
               next = BOT_NEXT;
            end else begin
               next = dec_s[WIDTH-1:0];
            end
         end
         default: begin
            next = value;
            term = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/updown_counter.sv
// N-bit modulo-M up/down counter with enable, synchronous load/reset and
// cascadable terminal-count output. Optional macro: COUNTER_SATURATE_EN.
module updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH     = 8,
   parameter longint MODULUS   = 256,
   parameter longint RESET_VAL = 0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CE,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] O,
   output logic             COUT,
   output logic             ZERO
);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("updown_counter: WIDTH must be in 2..32");
   end
   if (MODULUS < 64'sd2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
      $error("updown_counter: MODULUS must be in 2..2**WIDTH");
   end
   if (RESET_VAL < 64'sd0 || RESET_VAL >= MODULUS) begin : g_bad_reset
      $error("updown_counter: RESET_VAL must be below MODULUS");
   end

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] o_r;
   logic             zero_r;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] load_s;
   logic             term_s;

   assign load_s = WIDTH'(clamp_load(MAX_WIDTH'(D), MODULUS));

   updown_step #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_step (
      .value (o_r),
      .up    (UP),
      .next  (step_s),
      .term  (term_s)
   );

   // Load beats count beats hold; reset is applied in the register below.
   always_comb begin
      next_s = o_r;
      if (LOAD) begin
         next_s = load_s;
      end else if (CE) begin
         next_s = step_s;
      end else begin
         next_s = o_r;
      end
   end

   // Count register and ZERO flag, both taken from the same next value.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         o_r    <= RST_VAL;
         zero_r <= (RST_VAL == {WIDTH{1'b0}});
      end else begin
         o_r    <= next_s;
         zero_r <= (next_s == {WIDTH{1'b0}});
      end
   end

   assign O    = o_r;
   assign ZERO = zero_r;
   assign COUT = RESETN & CE & ~LOAD & term_s;

endmodule
